instruction_test_checker: RTL and testbench
===========================================

// Module: instruction_test_checker
// PURPOSE
//  Synthesizable, parametrised self-check engine for per-instruction core tests.
//  Starts the core, waits a fixed cycle budget or an early halt, then scans the
//  register file one entry per cycle through a read port. Each entry is compared
//  against a flattened expected image. Mismatches stream out on a valid/ready
//  channel; a pass/fail verdict and a mismatch count are posted at the end.
//  Sits beside RISC_V_Core in FPGA and bench tops, replacing the end-of-test dump.
// PARAMETERS
//  DATA_WIDTH     32   width of one register
//  NUM_REGS       32   register-file entries scanned (index 0..NUM_REGS-1)
//  INDEX_BITS     5    width of rd_index / mismatch_index (>= clog2(NUM_REGS))
//  TEST_LENGTH    100  core run budget in clock cycles before the scan starts
//  CNT_BITS       16   width of the internal run-cycle counter
// PORTS
//  clock             in   1                      system clock
//  reset             in   1                      async, active-high
//  start             in   1                      1-cycle request to run a test
//  halt              in   1                      core finished early (RUN only)
//  core_start        out  1                      1-cycle start pulse to core
//  expected_regs     in   NUM_REGS*DATA_WIDTH    entry k at [k*DATA_WIDTH +: DATA_WIDTH]
//  rd_index          out  INDEX_BITS             register-file read address
//  rd_data           in   DATA_WIDTH             combinational read data for rd_index
//  mismatch_valid    out  1                      mismatch record available
//  mismatch_ready    in   1                      consumer accepts record
//  mismatch_index    out  INDEX_BITS             failing register index
//  mismatch_expected out  DATA_WIDTH             expected value
//  mismatch_actual   out  DATA_WIDTH             value read
//  mismatch_count    out  clog2(NUM_REGS+1)      mismatches in this test
//  busy              out  1                      test in progress
//  done              out  1                      verdict valid (held)
//  test_passed       out  1                      1 when done and mismatch_count==0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE. All outputs 0, counters 0. No
//    partial result survives.
//  - FSM states: IDLE, KICK, RUN, SCAN, DRAIN, DONE.
//  - IDLE/DONE + start=1: go to KICK. DONE->KICK clears done, test_passed,
//    mismatch_count and mismatch_*. start is ignored while busy=1.
//  - KICK: core_start=1 for exactly this one cycle; busy=1 from KICK until DONE.
//  - RUN: counter counts 1..TEST_LENGTH. Go to SCAN on counter==TEST_LENGTH or
//    halt=1, whichever comes first. halt is ignored outside RUN.
//  - SCAN: rd_index=scan_idx (0 in all other states).
//    Compare rd_data with expected entry scan_idx in the same cycle.
//    On inequality: at the next edge drive mismatch_valid=1 with the index,
//    expected and actual values, and increment mismatch_count.
//  - Backpressure: while mismatch_valid=1 and mismatch_ready=0, scan_idx,
//    rd_index and all mismatch_* fields hold; no compare occurs.
//    A transfer happens on an edge where valid&&ready. A new mismatch in the
//    same cycle keeps valid=1 with new fields (back-to-back, no bubble).
//    Otherwise valid drops to 0.
//  - After compare of index NUM_REGS-1: go to DRAIN until no record is pending,
//    then DONE. DONE: done=1, busy=0, test_passed=(mismatch_count==0); both held.
//  - Latency, all match, no halt: core_start 1 cycle after start. Scan starts
//    TEST_LENGTH cycles after core_start. done rises NUM_REGS+1 cycles after
//    the scan starts.
//  - mismatch_count cannot overflow (max NUM_REGS). Every entry is compared;
//    entry 0 gets no special treatment.
// TESTING
//  1. Expected image == regfile, start at t0 -> core_start t1, done t1+100+33,
//     test_passed=1, count=0, mismatch_valid never high.
//  2. Expected[11]=0x00001000, [14]=0x00000001, actual 0, ready=1 -> records
//     (11,0x00001000,0), then (14,0x00000001,0); count=2, test_passed=0.
//  3. Same as 2, ready=0 for 5 cycles at first record -> fields and rd_index
//     stable 5 cycles, done 5 cycles later than in test 2.
//  4. halt=1 at 20th RUN cycle -> SCAN next cycle, done 33 cycles later.
//     halt during SCAN has no effect.
//  5. Assert reset mid-SCAN -> all outputs 0 immediately (async).
//     A following start gives a clean full run.
//  6. start pulses during RUN ignored. start in DONE after a failing test ->
//     results cleared in KICK, rerun passes with test_passed=1.

Source files
------------

// File: rtl/instruction_test_checker.sv
// instruction_test_checker: kicks the core, waits for a run budget or halt, then scans the
// register file against an expected image, streaming mismatch records and posting a verdict.
module instruction_test_checker #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int INDEX_BITS  = 5,
    parameter int TEST_LENGTH = 100,
    parameter int CNT_BITS    = 16,
    localparam int CW         = $clog2(NUM_REGS + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           halt,
    output logic                           core_start,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] expected_regs,
    output logic [INDEX_BITS-1:0]          rd_index,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           mismatch_valid,
    input  logic                           mismatch_ready,
    output logic [INDEX_BITS-1:0]          mismatch_index,
    output logic [DATA_WIDTH-1:0]          mismatch_expected,
    output logic [DATA_WIDTH-1:0]          mismatch_actual,
    output logic [CW-1:0]                  mismatch_count,
    output logic                           busy,
    output logic                           done,
    output logic                           test_passed
);
    typedef enum logic [2:0] {IDLE, KICK, RUN, SCAN, DRAIN, DONE} state_t;
    state_t state, state_next;
    logic [CNT_BITS-1:0]   cnt;
    logic [INDEX_BITS-1:0] scan_idx;
    logic [DATA_WIDTH-1:0] exp_arr [NUM_REGS];
    logic stall, cmp, miss, last, launch;
    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_exp
            assign exp_arr[g] = expected_regs[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate
    // An unaccepted record freezes the scan so the pending fields stay intact.
    assign stall  = mismatch_valid && !mismatch_ready;
    assign cmp    = state == SCAN && !stall;
    assign miss   = cmp && rd_data != exp_arr[scan_idx];
    assign last   = scan_idx == INDEX_BITS'(NUM_REGS - 1);
    assign launch = (state == IDLE || state == DONE) && start;
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        core_start = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        rd_index   = '0;
        case (state)
            IDLE:  state_next = start ? KICK : IDLE;
            KICK: begin
                core_start = 1'b1;
                busy       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                state_next = (halt || cnt == CNT_BITS'(TEST_LENGTH)) ? SCAN : RUN;
            end
            SCAN: begin
                busy       = 1'b1;
                rd_index   = scan_idx;
                state_next = (cmp && last) ? DRAIN : SCAN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = stall ? DRAIN : DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? KICK : DONE;
            end
            default: state_next = IDLE;
        endcase
        test_passed = done && mismatch_count == '0;
    end
    // The run counter is 1 in KICK, so the scan begins TEST_LENGTH cycles after core_start.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            cnt               <= '0;
            scan_idx          <= '0;
            mismatch_valid    <= 1'b0;
            mismatch_index    <= '0;
            mismatch_expected <= '0;
            mismatch_actual   <= '0;
            mismatch_count    <= '0;
        end else if (launch) begin
            cnt               <= CNT_BITS'(1);
            scan_idx          <= '0;
            mismatch_valid    <= 1'b0;
            mismatch_index    <= '0;
            mismatch_expected <= '0;
            mismatch_actual   <= '0;
            mismatch_count    <= '0;
        end else begin
            if (state == KICK || state == RUN) cnt <= cnt + 1'b1;
            if (cmp) begin
                scan_idx       <= scan_idx + 1'b1;
                mismatch_valid <= miss;
                if (miss) begin
                    mismatch_index    <= scan_idx;
                    mismatch_expected <= exp_arr[scan_idx];
                    mismatch_actual   <= rd_data;
                    mismatch_count    <= mismatch_count + 1'b1;
                end
            end else if (mismatch_valid && mismatch_ready) mismatch_valid <= 1'b0;
        end
endmodule

// File: tb/tb_instruction_test_checker.sv
// tb_instruction_test_checker: directed and randomized runs against a record-list and
// timing model derived from the checker's externally visible rules.
module tb_instruction_test_checker;
    localparam int DW = 32, NR = 32, IB = 5, TL = 100, CB = 16, CW = 6;
    logic clock = 0, reset = 1, start = 0, halt = 0, mismatch_ready = 1;
    logic [NR*DW-1:0] expected_regs = '0;
    logic core_start, mismatch_valid, busy, done, test_passed;
    logic [IB-1:0] rd_index, mismatch_index;
    logic [DW-1:0] rd_data, mismatch_expected, mismatch_actual;
    logic [CW-1:0] mismatch_count;
    logic [DW-1:0] regs [NR];
    int n_cmp = 0, n_bad = 0;
    typedef struct { int idx; logic [DW-1:0] e; logic [DW-1:0] a; } rec_t;

    instruction_test_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .INDEX_BITS(IB),
        .TEST_LENGTH(TL), .CNT_BITS(CB)) dut (
        .clock(clock), .reset(reset), .start(start), .halt(halt), .core_start(core_start),
        .expected_regs(expected_regs), .rd_index(rd_index), .rd_data(rd_data),
        .mismatch_valid(mismatch_valid), .mismatch_ready(mismatch_ready),
        .mismatch_index(mismatch_index), .mismatch_expected(mismatch_expected),
        .mismatch_actual(mismatch_actual), .mismatch_count(mismatch_count),
        .busy(busy), .done(done), .test_passed(test_passed));

    always #5 clock = ~clock;
    assign rd_data = regs[rd_index];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".core_start"}, core_start, 0);
        chk({tag, ".rd_index"}, rd_index, 0);
        chk({tag, ".valid"}, mismatch_valid, 0);
        chk({tag, ".m_index"}, mismatch_index, 0);
        chk({tag, ".m_exp"}, mismatch_expected, 0);
        chk({tag, ".m_act"}, mismatch_actual, 0);
        chk({tag, ".count"}, mismatch_count, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".passed"}, test_passed, 0);
    endtask

    task automatic set_image(input int nmiss, input bit edges);
        int k;
        for (int i = 0; i < NR; i++) begin
            regs[i] = $urandom;
            expected_regs[i*DW +: DW] = regs[i];
        end
        if (edges) begin
            expected_regs[0 +: DW] = regs[0] ^ 32'h8000_0001;
            expected_regs[(NR-1)*DW +: DW] = regs[NR-1] ^ 32'h0000_0100;
        end
        for (int i = 0; i < nmiss; i++) begin
            k = $urandom_range(0, NR - 1);
            expected_regs[k*DW +: DW] = regs[k] ^ ($urandom | 32'h1);
        end
    endtask

    // halt_at/start_at are cycle offsets from core_start (-1 = none); stall_req holds ready low
    // for that many cycles on the first record.
    task automatic run_test(input string name, input int halt_at, input bit halt_hold,
                            input int stall_req, input int start_at);
        rec_t q[$];
        rec_t r;
        int c, nrec, scan_start, stalls, stall_left;
        bit cap;
        logic [IB-1:0] c_idx, c_rd;
        logic [DW-1:0] c_e, c_a;
        for (int k = 0; k < NR; k++)
            if (expected_regs[k*DW +: DW] !== regs[k]) q.push_back('{k, expected_regs[k*DW +: DW], regs[k]});
        nrec = q.size();
        scan_start = (halt_at >= 0) ? halt_at + 1 : TL;
        start = 1;
        tick;
        start = 0;
        chk({name, ".kick_core_start"}, core_start, 1);
        chk({name, ".kick_busy"}, busy, 1);
        chk({name, ".kick_done"}, done, 0);
        chk({name, ".kick_passed"}, test_passed, 0);
        chk({name, ".kick_count"}, mismatch_count, 0);
        chk({name, ".kick_valid"}, mismatch_valid, 0);
        c = 0; stalls = 0; stall_left = stall_req; cap = 0;
        c_idx = '0; c_rd = '0; c_e = '0; c_a = '0;
        while (!done && c < 1000) begin
            if (c > 0) begin
                chk({name, ".core_start_low"}, core_start, 0);
                chk({name, ".busy"}, busy, 1);
            end
            halt = (c == halt_at) || (halt_hold && halt_at >= 0 && c > halt_at);
            start = (c == start_at);
            if (mismatch_valid) begin
                if (stall_left > 0) begin
                    mismatch_ready = 0;
                    if (!cap) begin
                        cap = 1; c_idx = mismatch_index; c_e = mismatch_expected;
                        c_a = mismatch_actual; c_rd = rd_index;
                    end else begin
                        chk({name, ".hold_idx"}, mismatch_index, c_idx);
                        chk({name, ".hold_exp"}, mismatch_expected, c_e);
                        chk({name, ".hold_act"}, mismatch_actual, c_a);
                        chk({name, ".hold_rd_index"}, rd_index, c_rd);
                    end
                    stall_left--;
                    stalls++;
                end else begin
                    mismatch_ready = 1;
                    if (q.size() == 0) chk({name, ".extra_record"}, 1, 0);
                    else begin
                        r = q.pop_front();
                        chk({name, ".rec_idx"}, mismatch_index, r.idx);
                        chk({name, ".rec_exp"}, mismatch_expected, r.e);
                        chk({name, ".rec_act"}, mismatch_actual, r.a);
                    end
                end
            end else mismatch_ready = 1'($urandom_range(0, 1));
            tick;
            c++;
        end
        halt = 0; start = 0; mismatch_ready = 1;
        chk({name, ".done"}, done, 1);
        chk({name, ".done_cycle"}, c, scan_start + NR + 1 + stalls);
        chk({name, ".missing_records"}, q.size(), 0);
        chk({name, ".count"}, mismatch_count, nrec);
        chk({name, ".passed"}, test_passed, nrec == 0);
        chk({name, ".busy_end"}, busy, 0);
        chk({name, ".valid_end"}, mismatch_valid, 0);
        tick;
        chk({name, ".done_held"}, done, 1);
        chk({name, ".passed_held"}, test_passed, nrec == 0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) regs[i] = '0;
        tick;
        tick;
        chk_zero("reset");
        reset = 0;
        tick;
        chk_zero("idle");
        set_image(0, 0);
        run_test("t1_match", -1, 0, 0, -1);
        for (int i = 0; i < NR; i++) begin
            regs[i] = '0;
            expected_regs[i*DW +: DW] = '0;
        end
        expected_regs[11*DW +: DW] = 32'h0000_1000;
        expected_regs[14*DW +: DW] = 32'h0000_0001;
        run_test("t2_two", -1, 0, 0, -1);
        run_test("t3_stall", -1, 0, 5, -1);
        set_image(0, 0);
        run_test("t4_halt", 20, 1, 0, -1);
        set_image(3, 1);
        start = 1;
        tick;
        start = 0;
        repeat (TL + 8) tick;
        #2 reset = 1;
        #1 chk_zero("t5_async_reset");
        tick;
        reset = 0;
        set_image(0, 0);
        run_test("t5_after_reset", -1, 0, 0, -1);
        set_image(4, 1);
        run_test("t6_fail_start_in_run", -1, 0, 3, 10);
        set_image(0, 0);
        run_test("t6_rerun", -1, 0, 0, -1);
        for (int n = 0; n < 4; n++) begin
            set_image($urandom_range(0, 6), 1'($urandom_range(0, 1)));
            run_test($sformatf("rnd%0d", n), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 90)) : -1,
                     1'($urandom_range(0, 1)), $urandom_range(0, 4), -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
